// File: rtl/ram_lsu.sv
// Single-port data RAM with valid/ready load/store handshake, byte-lane strobes,
// sign/zero extension and misalignment detection. Optional macro: RAM_LSU_ZERO_INIT_EN.
module ram_lsu #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_BITS = 10
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned BO     = $clog2(NBYTES);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_BITS];

    logic                  running;
    logic                  accept;
    logic                  req_err;
    logic                  wr_en;
    logic [DEPTH_BITS-1:0] idx;
    logic [BO-1:0]         offset;
    logic [3:0]            nbytes;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_strb;
    logic                  sign;
    logic                  unused_addr;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    assign idx         = i_req_addr[DEPTH_BITS+BO-1:BO];
    assign offset      = i_req_addr[BO-1:0];
    assign unused_addr = ^i_req_addr[ADDR_WIDTH-1:DEPTH_BITS+BO];
    assign nbytes      = 4'd1 << i_req_size;
    assign req_err     = (32'(i_req_size) > BO) || (|(i_req_addr[2:0] & 3'(nbytes - 4'd1)));

    assign o_req_ready = running && (!rsp_valid_q || i_rsp_ready);
    assign accept      = i_req_valid && o_req_ready;
    assign wr_en       = accept && i_req_we && !req_err;

    // Load path: shift the addressed lanes down, then fill the upper bytes.
    always_comb begin
        rd_shift = mem[idx] >> {offset, 3'b000};
        case (i_req_size)
            2'd0:    sign = rd_shift[7];
            2'd1:    sign = rd_shift[15];
            2'd2:    sign = rd_shift[31];
            default: sign = rd_shift[DATA_WIDTH-1];
        endcase
        ld_data = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (i < 32'(nbytes)) begin
                ld_data[8*i +: 8] = rd_shift[8*i +: 8];
            end else begin
                ld_data[8*i +: 8] = (sign && !i_req_unsigned) ? 8'hFF : 8'h00;
            end
        end
    end

    always_comb begin
        wr_data = i_req_wdata << {offset, 3'b000};
        wr_strb = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            wr_strb[i] = (i >= 32'(offset)) && (i < 32'(offset) + 32'(nbytes));
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = (req_err || i_req_we) ? '0 : ld_data;
        end else if (rsp_valid_q && i_rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

`ifdef RAM_LSU_ZERO_INIT_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_BITS-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + DEPTH_BITS'(1);
            if (&clr_cnt_q) state_d = ST_RUN;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign running = (state_q == ST_RUN);

    // Storage array carries no reset; the sweep zeroes it one word per cycle.
    always_ff @(posedge i_sys_clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_strb[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
`else
    assign running = 1'b1;

    always_ff @(posedge i_sys_clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_strb[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
`endif

endmodule
